spram_arbiter: RTL and testbench
================================

# spram_arbiter

Shares one up5k 16K×16 single-ported SPRAM (SB_SPRAM256KA) between two requesters through a round-robin req/gnt handshake. The block returns registered read data, and it places the macro in STANDBY after a programmable idle period, waking it on demand. It sits between the SPRAM primitive and two client engines, for example a FIFO writer and a hex-dump reader, so neither client muxes the RAM address or write-enable itself.

## Interface
- IDLE_CYCLES, 64: consecutive idle ACTIVE cycles before entering STANDBY; 0 disables standby.
- WAKE_CYCLES, 2: cycles spent in WAKE before grants resume; minimum 1.
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request; held high with its command until the matching gnt is seen.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  14  word address.
- wdata0 / wdata1  in  16  write data.
- mask0 / mask1  in  4  MASKWREN nibble enables; bits [1:0] = low byte, [3:2] = high byte.
- gnt0 / gnt1  out  1  combinational grant; the command executes on this clock edge.
- rvalid0 / rvalid1  out  1  one-cycle pulse the cycle after a granted read.
- rdata  out  16  SPRAM DATAOUT; valid only while an rvalid is high.
- sleeping  out  1  high in STANDBY and WAKE.

## Operation
- FSM states:
  - ACTIVE: grants allowed, STANDBY=0, CHIPSELECT=1.
  - SLEEP: STANDBY=1, CHIPSELECT=0, no grants.
  - WAKE: STANDBY=0, CHIPSELECT=0, counting WAKE_CYCLES, no grants.
- FSM transitions:
  - ACTIVE→SLEEP when idle_cnt reaches IDLE_CYCLES and neither req is high that cycle.
  - SLEEP→WAKE on any req.
  - WAKE→ACTIVE when wake_cnt reaches WAKE_CYCLES−1.
- Arbitration applies in ACTIVE only:
  - A single requester is granted immediately.
  - When both request, the grant goes to the port not granted last. `last` updates on every grant.
  - At most one gnt is high per cycle.
- SPRAM drive:
  - ADDRESS, DATAIN and MASKWREN come from the granted port.
  - WREN = gnt & we.
  - With no grant, WREN=0, and ADDRESS/DATAIN hold the port-0 values.
  - POWEROFF=1, SLEEP=0.
- Read return: a granted read sets rvalid for that port on the next cycle. rdata is DATAOUT, unregistered beyond the macro's own output register.
- idle_cnt:
  - Clears on any req.
  - Increments in ACTIVE otherwise and saturates at IDLE_CYCLES.
  - Clears on leaving ACTIVE.
- Reset values (asserted asynchronously):
  - State ACTIVE; idle_cnt, wake_cnt = 0.
  - `last` = 1, so port 0 wins the first tie.
  - rvalid0/1 = 0, sleeping = 0, CHIPSELECT = 0 while reset_n is low.
  - A read granted in the cycle of reset assertion never produces rvalid.

## Timing
- Grant latency: 0 cycles in ACTIVE, with gnt combinational from req/state.
- Read latency: rvalid one cycle after gnt. Back-to-back grants give one rvalid per cycle.
- Write: complete at the gnt edge. A read of the same address granted the next cycle returns the new data.
- Wake latency: req in SLEEP → first gnt after WAKE_CYCLES+1 cycles. With defaults: req at cycle n, WAKE at n+1..n+2, gnt at n+3.
- Simultaneous events:
  - A req in the same cycle the idle timeout expires wins; the FSM stays ACTIVE.
  - A req dropping while in WAKE does not abort WAKE; the FSM returns to ACTIVE and restarts the idle count.
- Client rules:
  - Clients must not change command fields while req is high and gnt is low.
  - Dropping req without a gnt is legal and has no effect.

## Structure
- Package spram_pkg holds:
  - The state enum {ACTIVE, SLEEP, WAKE}.
  - SPRAM_ADDR_BITS=14, SPRAM_DATA_BITS=16, SPRAM_MASK_BITS=4.
  - MASK_LO=4'b0011, MASK_HI=4'b1100, MASK_ALL=4'b1111.
- Sub-module spram_rr_arb2 contains the 2-way round-robin grant logic plus the `last` register (inputs req[1:0], enable; output gnt[1:0]).
- The top level holds the FSM, counters, rvalid registers and the SB_SPRAM256KA instance.

## Test plan
- Single write then read: port 0 writes 0xBEEF to addr 0x0005 with mask 1111, then reads it. Expect gnt0 on both cycles and rvalid0 with rdata=0xBEEF one cycle after the read grant.
- Contention: req0 and req1 held high for 6 cycles, all reads. Expect grants alternating 0,1,0,1,0,1 starting with port 0, and exactly one rvalid per cycle matching the previous grant.
- Byte mask: write 0x1234 with mask 1111, then 0xAB00 with mask 1100, then read. Expect 0xAB34.
- Standby: IDLE_CYCLES=4, no requests. Expect sleeping=1 after 4 idle cycles. req1 read then gives gnt1 exactly WAKE_CYCLES+1=3 cycles after req1 rose, with data preserved.
- Timeout race: req0 rises in the cycle idle_cnt reaches IDLE_CYCLES. Expect no STANDBY and gnt0 the same cycle.
- Reset mid-read: reset_n low in the cycle after a granted read. Expect rvalid0=0 immediately, state ACTIVE after release, and port 0 winning the first tie.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared state type, widths and mask constants for the SPRAM arbiter slice.
package spram_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    SLEEP  = 2'd1,
    WAKE   = 2'd2
  } spram_state_e;

  localparam int SPRAM_ADDR_BITS = 14;
  localparam int SPRAM_DATA_BITS = 16;
  localparam int SPRAM_MASK_BITS = 4;

  localparam logic [SPRAM_MASK_BITS-1:0] MASK_LO  = 4'b0011;
  localparam logic [SPRAM_MASK_BITS-1:0] MASK_HI  = 4'b1100;
  localparam logic [SPRAM_MASK_BITS-1:0] MASK_ALL = 4'b1111;

  // Each MASKWREN bit enables one nibble of the data word.
  function automatic logic [SPRAM_DATA_BITS-1:0] nibbleMask(input logic [SPRAM_MASK_BITS-1:0] m);
    logic [SPRAM_DATA_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < SPRAM_MASK_BITS; i++) begin
      r[4*i +: 4] = {4{m[i]}};
    end
    return r;
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// Two-client command/response bundle between the client engines and the SPRAM arbiter.
interface spram_arbiter_if;
  import spram_pkg::*;

  logic                       req0, req1;
  logic                       we0, we1;
  logic [SPRAM_ADDR_BITS-1:0] addr0, addr1;
  logic [SPRAM_DATA_BITS-1:0] wdata0, wdata1;
  logic [SPRAM_MASK_BITS-1:0] mask0, mask1;
  logic                       gnt0, gnt1;
  logic                       rvalid0, rvalid1;
  logic [SPRAM_DATA_BITS-1:0] rdata;
  logic                       sleeping;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, sleeping
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mask0, mask1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, sleeping
  );

endinterface

// File: rtl/sb_spram256ka.sv
// Behavioural stand-in for the iCE40 UP SB_SPRAM256KA macro (16K x 16, registered read port).
// Leave this file out of the build when the vendor cell library supplies the primitive.
module SB_SPRAM256KA
  import spram_pkg::*;
(
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);

  logic [15:0] mem [16384];
  logic        enabled;
  logic [15:0] bitMask;

  assign enabled = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;
  assign bitMask = nibbleMask(MASKWREN);

  // Contents survive standby; the output register only moves on a selected read.
  always_ff @(posedge CLOCK) begin
    if (enabled) begin
      if (WREN) begin
        mem[ADDRESS] <= (mem[ADDRESS] & ~bitMask) | (DATAIN & bitMask);
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end

endmodule

// File: rtl/spram_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the port that did not win last time.
module spram_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_i,
  input  logic       enable_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (enable_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) last_d = gnt_o[1];
    end
  end

  // last starts at 1 so port 0 wins the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/spram_arbiter.sv
// Shares one SB_SPRAM256KA between two clients with round-robin grants, read return
// and an idle-driven standby/wake power sequence.
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  spram_arbiter_if.slave bus
);

  localparam int IW = $clog2(IDLE_CYCLES + 2);
  localparam int WW = $clog2(WAKE_CYCLES + 2);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_CYCLES);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  spram_state_e   state_q, state_d;
  logic [IW-1:0]  idleCnt_q, idleCnt_d;
  logic [WW-1:0]  wakeCnt_q, wakeCnt_d;
  logic           rvalid0_q, rvalid1_q;
  logic           anyReq, arbEnable;
  logic [1:0]     gnt;
  logic [13:0]    ramAddr;
  logic [15:0]    ramData, ramOut;
  logic [3:0]     ramMask;
  logic           ramWren, ramStandby;

  assign anyReq = bus.req0 | bus.req1;

  always_comb begin
    state_d   = state_q;
    idleCnt_d = idleCnt_q;
    wakeCnt_d = '0;
    case (state_q)
      ACTIVE: begin
        if (anyReq) begin
          idleCnt_d = '0;
        end else if ((IDLE_CYCLES != 0) && (idleCnt_q == IDLE_MAX)) begin
          state_d   = SLEEP;
          idleCnt_d = '0;
        end else if (idleCnt_q != IDLE_MAX) begin
          idleCnt_d = idleCnt_q + IW'(1);
        end
      end
      SLEEP: begin
        idleCnt_d = '0;
        if (anyReq) state_d = WAKE;
      end
      WAKE: begin
        // A request that drops during wake-up does not abort it.
        idleCnt_d = '0;
        if (wakeCnt_q == WAKE_LAST) state_d = ACTIVE;
        else                        wakeCnt_d = wakeCnt_q + WW'(1);
      end
      default: begin
        state_d   = ACTIVE;
        idleCnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ACTIVE;
      idleCnt_q <= '0;
      wakeCnt_q <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idleCnt_q <= idleCnt_d;
      wakeCnt_q <= wakeCnt_d;
      rvalid0_q <= gnt[0] & ~bus.we0;
      rvalid1_q <= gnt[1] & ~bus.we1;
    end
  end

  // Gating with reset_n keeps the macro deselected and grant-free while reset is held.
  assign arbEnable = (state_q == ACTIVE) && reset_n;

  spram_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    ({bus.req1, bus.req0}),
    .enable_i (arbEnable),
    .gnt_o    (gnt)
  );

  assign ramAddr    = gnt[1] ? bus.addr1  : bus.addr0;
  assign ramData    = gnt[1] ? bus.wdata1 : bus.wdata0;
  assign ramMask    = gnt[1] ? bus.mask1  : bus.mask0;
  assign ramWren    = (gnt[0] & bus.we0) | (gnt[1] & bus.we1);
  assign ramStandby = (state_q == SLEEP);

  SB_SPRAM256KA u_spram (
    .ADDRESS    (ramAddr),
    .DATAIN     (ramData),
    .MASKWREN   (ramMask),
    .WREN       (ramWren),
    .CHIPSELECT (arbEnable),
    .CLOCK      (clk),
    .STANDBY    (ramStandby),
    .SLEEP      (1'b0),
    .POWEROFF   (1'b1),
    .DATAOUT    (ramOut)
  );

  assign bus.gnt0     = gnt[0];
  assign bus.gnt1     = gnt[1];
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rdata    = ramOut;
  assign bus.sleeping = (state_q != ACTIVE);

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed and randomised bench for spram_arbiter, compared every cycle against a
// behavioural model of the grant, read-return and standby rules.
module tb_spram_arbiter;
  import spram_pkg::*;

  localparam int IDLE = 4;
  localparam int WAKE = 2;
  localparam int M_AWAKE  = 0;
  localparam int M_ASLEEP = 1;
  localparam int M_WAKING = 2;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  spram_arbiter_if bus ();

  spram_arbiter #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  bit          chkEn = 1'b0;
  int          mMode, mIdleRun, mWakeLeft, mLast, mPendPort, cPort;
  bit          mPend;
  logic [15:0] mPendData, mPendKnown, cKm;
  logic [15:0] mMem   [16];
  logic [15:0] mKnown [16];
  logic [1:0]  mGnt, cR;
  logic [3:0]  cAddr;

  function automatic logic [15:0] expandMask(input logic [3:0] m);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = m[i] ? 4'hF : 4'h0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [13:0] addr, input logic [15:0] wdata, input logic [3:0] mask);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata; bus.mask0 = mask;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata; bus.mask1 = mask;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mMode = M_AWAKE; mIdleRun = 0; mWakeLeft = 0; mLast = 1; mPend = 1'b0; mGnt = 2'b00;
  endtask

  // A client holds an ungranted command (occasionally giving up), otherwise maybe issues a new one.
  task automatic randomClient(input int p, input int pct);
    logic       held;
    logic [3:0] m;
    held = ((p == 0) ? bus.req0 : bus.req1) && !mGnt[p];
    if (held && ($urandom_range(15) != 0)) return;
    case ($urandom_range(3))
      0:       m = MASK_ALL;
      1:       m = MASK_LO;
      2:       m = MASK_HI;
      default: m = 4'($urandom_range(15));
    endcase
    if ($urandom_range(99) < pct)
      applyStimulus(p, 1'b1, 1'($urandom_range(1)), 14'($urandom_range(15)), 16'($urandom), m);
    else
      applyStimulus(p, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
  endtask

  // Compare at the falling edge, then advance the model to what the next rising edge produces.
  always @(negedge clk) begin
    if (chkEn && reset_n) begin
      cR   = {bus.req1, bus.req0};
      mGnt = 2'b00;
      if (mMode == M_AWAKE) mGnt = (cR == 2'b11) ? ((mLast == 0) ? 2'b10 : 2'b01) : cR;
      checkOutput("gnt0", 32'(bus.gnt0), 32'(mGnt[0]));
      checkOutput("gnt1", 32'(bus.gnt1), 32'(mGnt[1]));
      checkOutput("sleeping", 32'(bus.sleeping), 32'(mMode != M_AWAKE));
      checkOutput("rvalid0", 32'(bus.rvalid0), 32'(mPend && (mPendPort == 0)));
      checkOutput("rvalid1", 32'(bus.rvalid1), 32'(mPend && (mPendPort == 1)));
      if (mPend && (mPendKnown != 16'h0))
        checkOutput("rdata", 32'(bus.rdata & mPendKnown), 32'(mPendData & mPendKnown));
      mPend = 1'b0;
      if (mGnt != 2'b00) begin
        cPort = mGnt[1] ? 1 : 0;
        mLast = cPort;
        cAddr = (cPort == 1) ? bus.addr1[3:0] : bus.addr0[3:0];
        if ((cPort == 1) ? bus.we1 : bus.we0) begin
          cKm = expandMask((cPort == 1) ? bus.mask1 : bus.mask0);
          mMem[cAddr]   = (mMem[cAddr] & ~cKm) | (((cPort == 1) ? bus.wdata1 : bus.wdata0) & cKm);
          mKnown[cAddr] = mKnown[cAddr] | cKm;
        end else begin
          mPend = 1'b1; mPendPort = cPort; mPendData = mMem[cAddr]; mPendKnown = mKnown[cAddr];
        end
      end
      case (mMode)
        M_AWAKE: begin
          if (cR != 2'b00) mIdleRun = 0;
          else if ((IDLE != 0) && (mIdleRun >= IDLE)) begin mMode = M_ASLEEP; mIdleRun = 0; end
          else if (mIdleRun < IDLE) mIdleRun++;
        end
        M_ASLEEP: if (cR != 2'b00) begin mMode = M_WAKING; mWakeLeft = WAKE; end
        default: begin
          mWakeLeft--;
          if (mWakeLeft == 0) begin mMode = M_AWAKE; mIdleRun = 0; end
        end
      endcase
    end
  end

  initial begin
    reset_n = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    applyStimulus(1, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    for (int i = 0; i < 16; i++) begin mMem[i] = 16'h0; mKnown[i] = 16'h0; end
    modelReset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gnt0", 32'(bus.gnt0), 32'd0);
    checkOutput("rst_sleeping", 32'(bus.sleeping), 32'd0);
    checkOutput("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    checkOutput("rst_rvalid1", 32'(bus.rvalid1), 32'd0);

    // Contention straight out of reset: port 0 first, then strict alternation.
    nextCycle();
    reset_n = 1'b1; modelReset(); chkEn = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    applyStimulus(1, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("tie_gnt0", 32'(bus.gnt0), 32'(i % 2 == 0));
      checkOutput("tie_gnt1", 32'(bus.gnt1), 32'(i % 2 == 1));
      if (i > 0) begin
        checkOutput("tie_rvalid0", 32'(bus.rvalid0), 32'((i - 1) % 2 == 0));
        checkOutput("tie_rvalid1", 32'(bus.rvalid1), 32'((i - 1) % 2 == 1));
      end
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    applyStimulus(1, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("tie_last_rvalid1", 32'(bus.rvalid1), 32'd1);

    // Single write then read-back on port 0.
    nextCycle(); applyStimulus(0, 1'b1, 1'b1, 14'd5, 16'hBEEF, MASK_ALL);
    @(negedge clk); checkOutput("wr_gnt0", 32'(bus.gnt0), 32'd1);
    nextCycle(); applyStimulus(0, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    @(negedge clk); checkOutput("rd_gnt0", 32'(bus.gnt0), 32'd1);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("rd_rvalid0", 32'(bus.rvalid0), 32'd1);
    checkOutput("rd_data", 32'(bus.rdata), 32'hBEEF);

    // Byte-masked overwrite of the high byte.
    nextCycle(); applyStimulus(0, 1'b1, 1'b1, 14'd9, 16'h1234, MASK_ALL);
    nextCycle(); applyStimulus(0, 1'b1, 1'b1, 14'd9, 16'hAB00, MASK_HI);
    nextCycle(); applyStimulus(0, 1'b1, 1'b0, 14'd9, 16'h0, MASK_ALL);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("mask_data", 32'(bus.rdata), 32'hAB34);

    // Idle into standby, then wake on a port-1 read.
    for (int k = 1; k <= 5; k++) begin
      nextCycle(); @(negedge clk);
      checkOutput("standby_sleeping", 32'(bus.sleeping), 32'(k == 5));
    end
    nextCycle(); applyStimulus(1, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("wake_gnt1", 32'(bus.gnt1), 32'(k == 3));
      checkOutput("wake_sleeping", 32'(bus.sleeping), 32'(k < 3));
      nextCycle();
    end
    applyStimulus(1, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("wake_rvalid1", 32'(bus.rvalid1), 32'd1);
    checkOutput("wake_data", 32'(bus.rdata), 32'hBEEF);

    // Request arriving in the timeout cycle keeps the RAM awake.
    for (int k = 0; k < 3; k++) begin
      nextCycle(); @(negedge clk);
      checkOutput("race_pre_sleeping", 32'(bus.sleeping), 32'd0);
    end
    nextCycle(); applyStimulus(0, 1'b1, 1'b0, 14'd9, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("race_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("race_sleeping", 32'(bus.sleeping), 32'd0);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    @(negedge clk);
    checkOutput("race_post_sleeping", 32'(bus.sleeping), 32'd0);
    checkOutput("race_data", 32'(bus.rdata), 32'hAB34);

    // Reset lands while a read result is on the bus and another read is being granted.
    nextCycle(); applyStimulus(0, 1'b1, 1'b0, 14'd9, 16'h0, MASK_ALL);
    @(negedge clk); checkOutput("rst_rd_gnt0", 32'(bus.gnt0), 32'd1);
    nextCycle();
    checkOutput("rst_pre_rvalid0", 32'(bus.rvalid0), 32'd1);
    chkEn = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_async_rvalid0", 32'(bus.rvalid0), 32'd0);
    checkOutput("rst_async_gnt0", 32'(bus.gnt0), 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 14'd5, 16'h0, MASK_ALL);
    nextCycle();
    checkOutput("rst_hold_rvalid0", 32'(bus.rvalid0), 32'd0);
    checkOutput("rst_hold_sleeping", 32'(bus.sleeping), 32'd0);
    reset_n = 1'b1; modelReset(); chkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_tie_gnt0", 32'(bus.gnt0), 32'd1);
    checkOutput("rst_tie_gnt1", 32'(bus.gnt1), 32'd0);

    // Random traffic: busy first, then sparse enough to exercise standby and wake.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      nextCycle();
      for (int p = 0; p < 2; p++) randomClient(p, (cyc < 2000) ? 40 : 8);
    end
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    applyStimulus(1, 1'b0, 1'b0, 14'd0, 16'h0, MASK_ALL);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
